// File: rtl/ds_dac_pkg.sv
// Shared types and sizing helpers for the multi-channel delta-sigma DAC.
package ds_dac_pkg;

  typedef enum logic {
    MODE_O1 = 1'b0,
    MODE_O2 = 1'b1
  } mode_e;

  // Second-order integrator widths; headroom above the W-bit sample.
  function automatic int i1_width(input int w);
    return w + 2;
  endfunction

  function automatic int i2_width(input int w);
    return w + 4;
  endfunction

endpackage

// File: rtl/ds_mod_ch.sv
// One delta-sigma modulator channel: first-order carry accumulator or
// saturating second-order loop, 1-bit registered output.
module ds_mod_ch
  import ds_dac_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  mode_e        mode_i,
  input  logic [W-1:0] x_i,
  output logic         dac_o
);

  localparam int I1W = i1_width(W);
  localparam int I2W = i2_width(W);

  typedef logic signed [I1W-1:0] i1_t;
  typedef logic signed [I2W-1:0] i2_t;
  typedef logic signed [I1W+1:0] i1s_t;
  typedef logic signed [I2W+1:0] i2s_t;

  localparam i1_t I1_MAX = {1'b0, {(I1W-1){1'b1}}};
  localparam i1_t I1_MIN = {1'b1, {(I1W-1){1'b0}}};
  localparam i2_t I2_MAX = {1'b0, {(I2W-1){1'b1}}};
  localparam i2_t I2_MIN = {1'b1, {(I2W-1){1'b0}}};

  localparam logic signed [W:0] Y_POS = {2'b01, {(W-1){1'b0}}};
  localparam logic signed [W:0] Y_NEG = {2'b11, {(W-1){1'b0}}};

  logic [W-1:0]       acc_q, acc_d;
  i1_t                i1_q, i1_d;
  i2_t                i2_q, i2_d;
  logic               dac_q, dac_d;

  logic [W:0]         acc_sum;
  logic signed [W:0]  u, y;
  i1s_t               i1_sum;
  i2s_t               i2_sum;
  i1_t                i1_sat;
  i2_t                i2_sat;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_d = acc_q;
    i1_d  = i1_q;
    i2_d  = i2_q;
    dac_d = 1'b0;

    acc_sum = {1'b0, acc_q} + {1'b0, x_i};

    // Offset-binary to two's complement is an MSB flip.
    u = {~x_i[W-1], ~x_i[W-1], x_i[W-2:0]};
    y = dac_q ? Y_POS : Y_NEG;

    i1_sum = i1s_t'(i1_q) + i1s_t'(u) - i1s_t'(y);
    if (i1_sum > i1s_t'(I1_MAX))      i1_sat = I1_MAX;
    else if (i1_sum < i1s_t'(I1_MIN)) i1_sat = I1_MIN;
    else                              i1_sat = i1_t'(i1_sum);

    // i2 integrates the freshly updated i1; this gives NTF = (1 - z^-1)^2.
    i2_sum = i2s_t'(i2_q) + i2s_t'(i1_sat) - i2s_t'(y);
    if (i2_sum > i2s_t'(I2_MAX))      i2_sat = I2_MAX;
    else if (i2_sum < i2s_t'(I2_MIN)) i2_sat = I2_MIN;
    else                              i2_sat = i2_t'(i2_sum);

    if (en_i) begin
      if (mode_i == MODE_O1) begin
        acc_d = acc_sum[W-1:0];
        dac_d = acc_sum[W];
      end else begin
        i1_d  = i1_sat;
        i2_d  = i2_sat;
        dac_d = ~i2_sat[I2W-1];
      end
      if (clr_i) begin
        acc_d = '0;
        i1_d  = '0;
        i2_d  = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      i1_q  <= '0;
      i2_q  <= '0;
      dac_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      dac_q <= dac_d;
    end
  end

  assign dac_o = dac_q;

endmodule

// File: rtl/ds_dac_multi.sv
// Multi-channel delta-sigma DAC: stream shadow register, OSR strobe counter,
// shared mode/underrun control, one ds_mod_ch per channel.
module ds_dac_multi
  import ds_dac_pkg::*;
#(
  parameter int NCH = 2,
  parameter int W   = 8,
  parameter int OSR = 256
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             EN_i,
  input  logic             ORDER2_i,
  input  logic             S_VALID_i,
  output logic             S_READY_o,
  input  logic [NCH*W-1:0] S_DATA_i,
  output logic             UNDERRUN_o,
  input  logic             CLR_UNDERRUN_i,
  output logic [NCH-1:0]   DACout_o
);

  localparam int              CW       = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(OSR - 1);
  localparam logic [W-1:0]    MID      = {1'b1, {(W-1){1'b0}}};

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NCH*W-1:0]   shadow_q, shadow_d;
  logic               full_q, full_d;
  logic [NCH*W-1:0]   active_q, active_d;
  mode_e              mode_q, mode_d;
  logic               underrun_q, underrun_d;

  logic               strobe;
  logic               accept;
  logic               mode_clr;

  always_comb begin
    strobe   = EN_i && (cnt_q == CNT_LAST);
    accept   = S_VALID_i && !full_q;
    mode_clr = strobe && (mode_e'(ORDER2_i) != mode_q);

    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    full_d     = full_q;
    active_d   = active_q;
    mode_d     = mode_q;
    underrun_d = underrun_q;

    if (EN_i) cnt_d = strobe ? '0 : cnt_q + CW'(1);

    if (strobe) begin
      mode_d = mode_e'(ORDER2_i);
      if (full_q) begin
        active_d = shadow_q;
        full_d   = 1'b0;
      end
    end

    // accept implies the shadow was empty, so it never collides with the move above.
    if (accept) begin
      shadow_d = S_DATA_i;
      full_d   = 1'b1;
    end

    if (strobe && !full_q)    underrun_d = 1'b1;
    else if (CLR_UNDERRUN_i)  underrun_d = 1'b0;
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      cnt_q      <= '0;
      full_q     <= 1'b0;
      active_q   <= {NCH{MID}};
      mode_q     <= MODE_O1;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      active_q   <= active_d;
      mode_q     <= mode_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: the shadow data needs no reset; full_q alone decides whether it is
  // ever read, so a reset only has to clear the flag.
  always_ff @(posedge CLK_i) begin
    shadow_q <= shadow_d;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    ds_mod_ch #(.W(W)) u_ch (
      .clk_i  (CLK_i),
      .rst_i  (RST_i),
      .en_i   (EN_i),
      .clr_i  (mode_clr),
      .mode_i (mode_q),
      .x_i    (active_q[c*W +: W]),
      .dac_o  (DACout_o[c])
    );
  end

  assign S_READY_o  = ~full_q;
  assign UNDERRUN_o = underrun_q;

endmodule

// File: tb/tb_ds_dac_multi.sv
// Directed bench for ds_dac_multi: integer reference model compared every
// cycle, plus literal ones-count and flag expectations.
module tb_ds_dac_multi;

  localparam int NCH   = 2;
  localparam int W     = 8;
  localparam int OSR   = 256;
  localparam int HALF  = 1 << (W - 1);
  localparam int FULL  = 1 << W;
  localparam int I1MAX = (1 << (W + 1)) - 1;
  localparam int I1MIN = -(1 << (W + 1));
  localparam int I2MAX = (1 << (W + 3)) - 1;
  localparam int I2MIN = -(1 << (W + 3));

  logic             clk = 1'b0;
  logic             rst, en, order2, s_valid, clr_und;
  logic [NCH*W-1:0] s_data;
  logic             s_ready, underrun;
  logic [NCH-1:0]   dac;

  always #5 clk = ~clk;

  ds_dac_multi #(.NCH(NCH), .W(W), .OSR(OSR)) dut (
    .CLK_i          (clk),
    .RST_i          (rst),
    .EN_i           (en),
    .ORDER2_i       (order2),
    .S_VALID_i      (s_valid),
    .S_READY_o      (s_ready),
    .S_DATA_i       (s_data),
    .UNDERRUN_o     (underrun),
    .CLR_UNDERRUN_i (clr_und),
    .DACout_o       (dac)
  );

  int vectors = 0;
  int miscompares = 0;
  int ones[NCH];

  // Reference model state, plain integers.
  int m_cnt;
  bit m_full, m_und, m_mode;
  int m_shadow[NCH], m_act[NCH], m_acc[NCH], m_i1[NCH], m_i2[NCH];
  bit m_out[NCH];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int model_dac();
    int v = 0;
    for (int c = 0; c < NCH; c++) if (m_out[c]) v += (1 << c);
    return v;
  endfunction

  // Next state for the coming rising edge, from the inputs now applied.
  task automatic model_step();
    bit strobe, accept, full_old;
    if (rst) begin
      m_cnt = 0; m_full = 0; m_und = 0; m_mode = 0;
      for (int c = 0; c < NCH; c++) begin
        m_act[c] = HALF; m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_out[c] = 0;
      end
    end else begin
      strobe   = en && (m_cnt == OSR - 1);
      accept   = s_valid && !m_full;
      full_old = m_full;
      for (int c = 0; c < NCH; c++) begin
        if (!en) begin
          m_out[c] = 0;
        end else if (!m_mode) begin
          int s;
          s = m_acc[c] + m_act[c];
          m_out[c] = (s >= FULL);
          m_acc[c] = s % FULL;
        end else begin
          int u, y;
          u = m_act[c] - HALF;
          y = m_out[c] ? HALF : -HALF;
          m_i1[c]  = sat(m_i1[c] + u - y, I1MIN, I1MAX);
          m_i2[c]  = sat(m_i2[c] + m_i1[c] - y, I2MIN, I2MAX);
          m_out[c] = (m_i2[c] >= 0);
        end
      end
      if (strobe) begin
        if (order2 != m_mode)
          for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; end
        m_mode = order2;
        if (full_old) begin
          for (int c = 0; c < NCH; c++) m_act[c] = m_shadow[c];
          m_full = 0;
        end
      end
      if (strobe && !full_old) m_und = 1;
      else if (clr_und)        m_und = 0;
      if (accept) begin
        for (int c = 0; c < NCH; c++) m_shadow[c] = int'(s_data[c*W +: W]);
        m_full = 1;
      end
      if (en) m_cnt = (m_cnt == OSR - 1) ? 0 : m_cnt + 1;
    end
  endtask

  // One clock: advance model, let the edge pass, compare on the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("DACout_o", int'(dac), model_dac());
    check("S_READY_o", int'(s_ready), int'(!m_full));
    check("UNDERRUN_o", int'(underrun), int'(m_und));
    for (int c = 0; c < NCH; c++) ones[c] += int'(dac[c]);
  endtask

  task automatic clear_ones();
    for (int c = 0; c < NCH; c++) ones[c] = 0;
  endtask

  task automatic run_to_cnt(input int k);
    int n = 0;
    do begin
      tick();
      n++;
    end while (m_cnt != k && n < OSR + 2);
    if (m_cnt != k) begin
      vectors++;
      miscompares++;
      $display("FAIL cnt_reach: count %0d, wanted %0d within %0d cycles", m_cnt, k, OSR + 2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; order2 = 1'b0; s_valid = 1'b0; clr_und = 1'b0; s_data = '0;
    clear_ones();
    tick();
    tick();
    check("reset_ready", int'(s_ready), 1);
    check("reset_underrun", int'(underrun), 0);
    check("reset_dac", int'(dac), 0);

    // Mid-scale, no samples, first order.
    rst = 1'b0; en = 1'b1;
    clear_ones();
    repeat (256) tick();
    check("mid_ones_ch0", ones[0], 128);
    check("mid_ones_ch1", ones[1], 128);
    check("first_strobe_underrun", int'(underrun), 1);

    // ch0=64, ch1=255.
    s_valid = 1'b1; s_data = {8'd255, 8'd64};
    tick();
    s_valid = 1'b0;
    check("loaded_not_ready", int'(s_ready), 0);
    run_to_cnt(0);
    check("strobe_frees_shadow", int'(s_ready), 1);
    clear_ones();
    repeat (256) tick();
    check("x64_ones_ch0", ones[0], 64);
    check("x255_ones_ch1", ones[1], 255);

    // Back-to-back words: second stalls until the strobe.
    run_to_cnt(100);
    clr_und = 1'b1;
    tick();
    clr_und = 1'b0;
    check("clr_underrun", int'(underrun), 0);
    s_valid = 1'b1; s_data = {8'd0, 8'd0};
    tick();
    s_data = {8'd128, 8'd192};
    tick();
    check("b2b_stall", int'(s_ready), 0);
    run_to_cnt(0);
    check("b2b_ready_after_strobe", int'(s_ready), 1);
    tick();
    check("b2b_second_accepted", int'(s_ready), 0);
    s_valid = 1'b0;
    check("b2b_no_underrun", int'(underrun), 0);

    // Code 0 first order, then switch to second order at the next strobe.
    order2 = 1'b1;
    clear_ones();
    repeat (200) tick();
    check("o1_code0_ch0", ones[0], 0);
    check("o1_code0_ch1", ones[1], 0);
    run_to_cnt(0);
    clear_ones();
    repeat (1024) tick();
    check_range("o2_x192_ch0", ones[0], 764, 772);
    check_range("o2_x128_ch1", ones[1], 508, 516);

    // Transfer on a strobe with empty shadow.
    clr_und = 1'b1;
    tick();
    clr_und = 1'b0;
    check("clr_underrun2", int'(underrun), 0);
    run_to_cnt(OSR - 1);
    s_valid = 1'b1; s_data = {8'd0, 8'd0};
    tick();
    s_valid = 1'b0;
    check("strobe_xfer_underrun", int'(underrun), 1);
    check("strobe_xfer_to_shadow", int'(s_ready), 0);
    run_to_cnt(0);
    check("strobe_xfer_moved", int'(s_ready), 1);
    run_to_cnt(OSR - 1);
    clr_und = 1'b1;
    tick();
    clr_und = 1'b0;
    check("set_wins_over_clear", int'(underrun), 1);
    clr_und = 1'b1;
    tick();
    clr_und = 1'b0;
    check("clear_after_set", int'(underrun), 0);

    // Code 0 second order settles to all zeros.
    repeat (300) tick();
    clear_ones();
    repeat (200) tick();
    check("o2_code0_ch0", ones[0], 0);
    check("o2_code0_ch1", ones[1], 0);

    // Disable for 100 cycles with a word arriving meanwhile.
    run_to_cnt(10);
    en = 1'b0;
    clear_ones();
    s_valid = 1'b1; s_data = {8'd50, 8'd200};
    tick();
    s_valid = 1'b0;
    check("disabled_handshake", int'(s_ready), 0);
    repeat (99) tick();
    check("disabled_ones", ones[0] + ones[1], 0);
    en = 1'b1;
    repeat (3) tick();
    check("shadow_full_before_reset", int'(s_ready), 0);

    // Reset with full shadow.
    rst = 1'b1; order2 = 1'b0;
    tick();
    rst = 1'b0;
    check("rst2_ready", int'(s_ready), 1);
    check("rst2_underrun", int'(underrun), 0);
    check("rst2_dac", int'(dac), 0);
    clear_ones();
    repeat (256) tick();
    check("rst2_mid_ch0", ones[0], 128);
    check("rst2_mid_ch1", ones[1], 128);
    check("rst2_shadow_discarded", int'(underrun), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ds_dac_multi.md
Name: ds_dac_multi

Overview:
- Multi-channel delta-sigma DAC with selectable first- or second-order noise shaping.
- Per channel: one 1-bit pulse-density output, driven to a pin and an external RC low-pass filter.
- Samples enter over a valid/ready stream into a shadow register. They are transferred to all channels atomically on an internal update strobe every OSR clocks.
- Sits between the audio/sample source and the I/O pins.

Parameters:
- NCH, 2, number of channels
- W, 8, sample width per channel; offset-binary (excess 2^(W-1)) unsigned code
- OSR, 256, clocks per sample update strobe (>=4)

Ports:
- CLK_i  in  1  clock
- RST_i  in  1  synchronous reset, active-high
- EN_i  in  1  modulator enable
- ORDER2_i  in  1  0 = first-order, 1 = second-order; sampled only on the update strobe
- S_VALID_i  in  1  sample word valid
- S_READY_o  out  1  shadow register empty, can accept
- S_DATA_i  in  NCH*W  channel c in bits [c*W+W-1 : c*W]
- UNDERRUN_o  out  1  sticky: strobe occurred with shadow empty
- CLR_UNDERRUN_i  in  1  clears UNDERRUN_o
- DACout_o  out  NCH  registered 1-bit outputs, one per channel

Behaviour:
- Reset (RST_i=1 at CLK_i edge):
  - DACout_o=0, S_READY_o=1, UNDERRUN_o=0, strobe counter=0, mode register=first-order.
  - Active samples = 2^(W-1) (mid-scale); all integrators=0.
  - Reset mid-stream discards the shadow contents.
- Handshake:
  - Transfer when S_VALID_i & S_READY_o; shadow loads S_DATA_i and S_READY_o drops next cycle.
  - S_READY_o is independent of S_VALID_i, so there is no combinational path.
- Strobe counter: counts 0..OSR-1 while EN_i=1, holds while EN_i=0. strobe=1 in the cycle the count equals OSR-1; the count wraps to 0.
- On strobe:
  - If shadow full: active <= shadow and shadow marked empty. S_READY_o=1 next cycle.
  - If a transfer happens in the same cycle as a strobe with shadow empty: the new word goes to shadow, not active; UNDERRUN is set (strobe saw empty).
  - If shadow empty: active holds and UNDERRUN_o <= 1.
  - CLR_UNDERRUN_i and a simultaneous underrun: set wins.
  - Mode register <= ORDER2_i. If the mode changes, all integrators clear to 0 in that same edge.
- First-order, per channel:
  - State acc (W bits).
  - Each EN cycle: {carry, acc} <= acc + x, where x is the active code; DACout_o[c] <= carry.
  - Ones density is exactly x/2^W over any 2^W-cycle window with constant x.
- Second-order, per channel:
  - Signed terms: u = x - 2^(W-1); y = +2^(W-1) if DACout_o[c] else -2^(W-1).
  - Integrators: i1 <= i1 + u - y (W+2 bits signed); i2 <= i2 + i1 - y (W+4 bits signed).
  - Both integrators saturate at their signed limits; no wrap.
  - DACout_o[c] <= (i2_next >= 0).
- Latency: the first DACout_o bit influenced by a new active sample appears 2 cycles after the strobe edge.
- EN_i=0: integrators, counter and active samples hold; DACout_o <= 0. Handshake still operates.
- All channels share the strobe, mode and underrun logic.

Decomposition:
- Package ds_dac_pkg: mode encoding constants (MODE_O1, MODE_O2) and integrator-width functions (W+2, W+4).
- Sub-module ds_mod_ch, instantiated NCH times. It holds the per-channel modulator (active sample in, mode, enable, clear; 1-bit registered out).
- The top level holds the shadow register, handshake, strobe counter, mode register and underrun flag.

Test Plan:
- Reset then EN=1, no samples, first-order: every channel at code 128 gives exactly 128 ones per 256 cycles (alternating 0/1); UNDERRUN_o=1 after the first strobe.
- Send ch0=64, ch1=255 before the strobe, OSR=256: after strobe+2, ch0 gives exactly 64 ones per 256 cycles (pattern period 4) and ch1 gives 255 ones per 256 cycles.
- Code 0 in first- and second-order: DACout_o stays 0 after settling.
- ORDER2_i=1 at a strobe with ch0=192: integrators clear; over 1024 cycles the ones count is 768±4; i1/i2 never exceed their saturation limits.
- Back-to-back S_VALID_i: the second word stalls (S_READY_o=0) until the next strobe, then is accepted; a transfer on the strobe cycle with shadow empty sets UNDERRUN_o; CLR_UNDERRUN_i clears it.
- EN_i=0 for 100 cycles mid-stream, then RST_i pulse during a full shadow: outputs 0 while disabled, counter frozen; after reset S_READY_o=1, shadow discarded, active back to mid-scale.
